// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the RV32I-subset datapath: steps each
// instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           ula_src_a,
  output logic [1:0]           ula_src_b,
  output logic [2:0]           ula_control,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_ALU_WB    = 4'd8,
    S_TRAP      = 4'd9
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Both decoders return {legal, alu_op}.
  function automatic logic [3:0] r_decode(input logic [2:0] f3, input logic [6:0] f7);
    case ({f3, f7})
      {3'b000, 7'b0000000}: r_decode = {1'b1, ALU_ADD};
      {3'b000, 7'b0100000}: r_decode = {1'b1, ALU_SUB};
      {3'b111, 7'b0000000}: r_decode = {1'b1, ALU_AND};
      {3'b110, 7'b0000000}: r_decode = {1'b1, ALU_OR};
      {3'b010, 7'b0000000}: r_decode = {1'b1, ALU_SLT};
      default:              r_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [3:0] i_decode(input logic [2:0] f3);
    case (f3)
      3'b000:  i_decode = {1'b1, ALU_ADD};
      3'b010:  i_decode = {1'b1, ALU_SLT};
      3'b110:  i_decode = {1'b1, ALU_OR};
      3'b111:  i_decode = {1'b1, ALU_AND};
      default: i_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [3:0]             r_dec;
  logic [3:0]             i_dec;
  logic                   retire;

  assign r_dec = r_decode(funct3, funct7);
  assign i_dec = i_decode(funct3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_R)                                           state_d = S_EXEC_R;
        else if (op == OP_I)                                      state_d = S_EXEC_I;
        else if ((op == OP_LW || op == OP_SW) && funct3 == 3'b010) state_d = S_MEM_ADDR;
        else                                                      state_d = S_TRAP;
      end
      S_EXEC_R:    state_d = r_dec[3] ? S_ALU_WB : S_TRAP;
      S_EXEC_I:    state_d = i_dec[3] ? S_ALU_WB : S_TRAP;
      // IR is still stable here, so the opcode tells load from store.
      S_MEM_ADDR:  state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_ALU_WB:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  always_comb begin
    retire    = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                ((state_q == S_MEM_WRITE) && mem_ready);
    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    ula_src_a   = 2'b00;
    ula_src_b   = 2'b00;
    ula_control = ALU_ADD;
    result_src  = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ula_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_EXEC_R: begin
        ula_src_a   = 2'b10;
        ula_control = r_dec[2:0];
      end
      S_EXEC_I: begin
        ula_src_a   = 2'b10;
        ula_src_b   = 2'b01;
        ula_control = i_dec[2:0];
      end
      S_MEM_ADDR: begin
        ula_src_a = 2'b10;
        ula_src_b = 2'b01;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_TRAP:   illegal   = 1'b1;
      default:  ;
    endcase
    // Reset masks every strobe so nothing reaches the datapath or memory.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      ula_src_a   = 2'b00;
      ula_src_b   = 2'b00;
      ula_control = ALU_ADD;
      result_src  = 2'b00;
      illegal     = 1'b0;
    end
  end

  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the RV32I-subset datapath. It replaces single-cycle decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared ALU, the register-file write strobe, the PC/IR write enables and a request/ready handshake to the unified instruction/data memory. It also counts retired instructions and traps on unsupported encodings.

## Interface
Parameters:
- INSTRET_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  IR[6:0] from datapath instruction register
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address: 0 = PC, 1 = ALU result register
- ir_write  out  1  load IR (and OldPC)
- pc_write  out  1  load PC from ALU result
- reg_write  out  1  register-file write enable
- ula_src_a  out  2  00 = PC, 10 = rs1 register; 01 reserved
- ula_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- ula_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
- result_src  out  2  00 = ALU result register, 01 = memory data register, 10 = ALU output direct
- illegal  out  1  sticky trap flag
- instret  out  INSTRET_W  retired-instruction count
- state_dbg  out  4  current state encoding

## Operation
- States, in encoding order 0–8: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB; TRAP = 9.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, adr_src=0, ula_src_a=00, ula_src_b=10, ula_control=ADD, result_src=10.
  - ir_write = pc_write = mem_ready (combinational).
  - mem_ready=1 → DECODE; otherwise hold.
- DECODE: no strobes. Next state by op:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 with funct3=010 → MEM_ADDR (lw)
  - 0100011 with funct3=010 → MEM_ADDR (sw)
  - else → TRAP
- EXEC_R: ula_src_a=10, ula_src_b=00. {funct3,funct7} selects the ALU op:
  - {000,0000000} ADD
  - {000,0100000} SUB
  - {111,0000000} AND
  - {110,0000000} OR
  - {010,0000000} SLT
  - Match → ALU_WB; any other combination → TRAP.
- EXEC_I: ula_src_a=10, ula_src_b=01. funct3 selects the ALU op:
  - 000 ADD, 010 SLT, 110 OR, 111 AND; funct7 ignored.
  - Match → ALU_WB; other funct3 → TRAP.
- MEM_ADDR: ula_src_a=10, ula_src_b=01, ADD. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, adr_src=1. mem_ready → MEM_WB.
- MEM_WB: reg_write=1, result_src=01. Retire → FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, adr_src=1. mem_ready → retire → FETCH.
- ALU_WB: reg_write=1, result_src=00. Retire → FETCH.
- TRAP: illegal=1, all strobes 0. Held until rst.
- Retire: instret increments by 1 on the edge that leaves ALU_WB, MEM_WB, or MEM_WRITE with mem_ready. Wraps from all-ones to 0 with no flag.

## Timing
- Reset: on any rising edge with rst=1:
  - state ← FETCH, instret ← 0, illegal ← 0.
  - While rst=1, all outputs except state_dbg and instret are forced 0 combinationally.
  - The first mem_req appears in the cycle after rst deasserts.
- Reset mid-instruction (including during a pending memory wait) aborts with no writeback and no retire.
- Handshake:
  - mem_req stays asserted with stable adr_src/mem_we until a cycle with mem_ready=1.
  - The access completes on that edge; zero-wait (mem_ready already high) is legal.
  - mem_ready is ignored in every state without mem_req.
- Latency with zero-wait memory: R/I = 4 cycles, lw = 5, sw = 4. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- Decode inputs (op/funct3/funct7) are sampled only in DECODE, EXEC_R, EXEC_I and MEM_ADDR; the IR is stable there.
- Outputs are Moore-decoded from state, except ir_write/pc_write, which are Mealy on mem_ready in FETCH.

## Test plan
- Reset then add, mem_ready tied 1:
  - state_dbg sequence 0,1,2,8,0.
  - In EXEC_R: ula_control=000, ula_src_b=00. In ALU_WB: reg_write=1.
  - instret=1 after the 4th edge.
- sub (funct7=0100000), then slti (op 0010011, funct3 010):
  - ula_control 001, then 101 with ula_src_b=01.
  - instret=2 after 8 cycles.
- lw with mem_ready low 3 cycles in MEM_READ:
  - mem_req=1, adr_src=1 held 4 cycles; then MEM_WB with result_src=01, reg_write=1.
  - 8 cycles total.
- sw, zero-wait: MEM_WRITE asserts mem_req=1, mem_we=1, reg_write=0. Returns to FETCH after 4 cycles.
- Illegal cases (op 1100011, and R-type funct7=0000001):
  - TRAP entered, illegal=1, strobes 0 for 20 cycles, instret unchanged.
  - rst=1 for one cycle clears illegal and returns to FETCH.
- Counter and reset:
  - Force instret to all-ones via retire count with INSTRET_W=4 (15 adds + 1) → wraps to 0.
  - rst asserted during a FETCH wait → next state FETCH, no pc_write pulse.
